// File: rtl/core_peripheral_port_pkg.sv
// Shared definitions for the core peripheral port: command/report type codes and TX FSM states.
package core_peripheral_port_pkg;

   localparam logic [1:0] PERIPH_REPORT = 2'b00;
   localparam logic [1:0] PERIPH_START  = 2'b01;
   localparam logic [1:0] PERIPH_DATA   = 2'b10;
   localparam logic [1:0] PERIPH_CTRL   = 2'b11;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StSend = 2'b01,
      StGap  = 2'b10
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH      = 34,
   parameter int unsigned DEPTH_BITS = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_BITS:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_BITS;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  do_push, do_pop;

   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == (DEPTH_BITS+1)'(DEPTH));
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + DEPTH_BITS'(do_push);
      rd_ptr_d = rd_ptr_q + DEPTH_BITS'(do_pop);
      count_d  = count_q + (DEPTH_BITS+1)'(do_push) - (DEPTH_BITS+1)'(do_pop);
      rdata    = mem_q[rd_ptr_q];
      count    = count_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; entries are only visible once count covers them.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/core_peripheral_port.sv
// Peripheral endpoint of the core link: RX reports are queued for the host, host commands
// are sent to the core as single-cycle pulses separated by a fixed idle gap.
module core_peripheral_port
   import core_peripheral_port_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH_BITS = 3,
   parameter int unsigned TX_GAP     = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            to_peripheral,
   input  logic [DATA_WIDTH-1:0] to_peripheral_data,
   input  logic                  to_peripheral_valid,
   output logic [1:0]            from_peripheral,
   output logic [DATA_WIDTH-1:0] from_peripheral_data,
   output logic                  from_peripheral_valid,
   output logic [1:0]            host_rx_type,
   output logic [DATA_WIDTH-1:0] host_rx_data,
   output logic                  host_rx_valid,
   input  logic                  host_rx_ready,
   input  logic [1:0]            host_tx_type,
   input  logic [DATA_WIDTH-1:0] host_tx_data,
   input  logic                  host_tx_valid,
   output logic                  host_tx_ready,
   output logic [DEPTH_BITS:0]   rx_count,
   output logic                  rx_overflow,
   input  logic                  clear_overflow
);

   localparam int unsigned GapW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

   logic                  rx_full, rx_empty, rx_drop;
   logic                  overflow_q, overflow_d;
   tx_state_e             state_q, state_d;
   logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
   logic [1:0]            fp_type_q, fp_type_d;
   logic [DATA_WIDTH-1:0] fp_data_q, fp_data_d;

   sync_fifo #(
      .WIDTH      (DATA_WIDTH + 2),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (to_peripheral_valid),
      .pop   (host_rx_ready),
      .wdata ({to_peripheral, to_peripheral_data}),
      .rdata ({host_rx_type, host_rx_data}),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   // A full FIFO is never empty, so a same-edge pop always frees the slot.
   always_comb begin
      rx_drop       = to_peripheral_valid & rx_full & ~host_rx_ready;
      overflow_d    = rx_drop | (overflow_q & ~clear_overflow);
      host_rx_valid = ~rx_empty;
      rx_overflow   = overflow_q;
   end

   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      fp_type_d = fp_type_q;
      fp_data_d = fp_data_q;
      unique case (state_q)
         StIdle: begin
            if (host_tx_valid) begin
               fp_type_d = host_tx_type;
               fp_data_d = host_tx_data;
               state_d   = StSend;
            end
         end
         StSend: begin
            gap_cnt_d = '0;
            state_d   = (TX_GAP > 0) ? StGap : StIdle;
         end
         StGap: begin
            if (gap_cnt_q == GapW'(TX_GAP - 1)) begin
               state_d = StIdle;
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      from_peripheral       = fp_type_q;
      from_peripheral_data  = fp_data_q;
      from_peripheral_valid = (state_q == StSend);
      host_tx_ready         = (state_q == StIdle) & ~reset;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
         state_q    <= StIdle;
         gap_cnt_q  <= '0;
         fp_type_q  <= PERIPH_REPORT;
         fp_data_q  <= '0;
      end else begin
         overflow_q <= overflow_d;
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         fp_type_q  <= fp_type_d;
         fp_data_q  <= fp_data_d;
      end
   end

endmodule
